// File: rtl/rf_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_seq_if
//  Description : Command handshake and register-file port bundle for rf_seq.
//                master = command source / register-file owner,
//                slave  = the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [15:0] cmd_imm;

    logic [2:0]  rf_rd_addr_a;
    logic [2:0]  rf_rd_addr_b;
    logic [15:0] rf_d_out_a;
    logic [15:0] rf_d_out_b;
    logic        rf_wr;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_d_in;

    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_c;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output rf_d_out_a, rf_d_out_b,
        input  cmd_ready, rf_rd_addr_a, rf_rd_addr_b,
        input  rf_wr, rf_wr_addr, rf_d_in,
        input  done, result, flag_z, flag_c
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  rf_d_out_a, rf_d_out_b,
        output cmd_ready, rf_rd_addr_a, rf_rd_addr_b,
        output rf_wr, rf_wr_addr, rf_d_in,
        output done, result, flag_z, flag_c
    );
endinterface
`default_nettype wire

// File: rtl/rf_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rf_seq
//  Description : Four-state register-file sequencer. Accepts one ALU command,
//                reads two operands from an external register file, computes
//                a 16-bit result with zero/carry flags and writes it back.
//                One command every four cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_seq (
    input  wire logic clk,
    input  wire logic reset,
    rf_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_xor = 3'b100;
    localparam logic [2:0] c_op_not = 3'b101;
    localparam logic [2:0] c_op_mov = 3'b110;
    localparam logic [2:0] c_op_ldi = 3'b111;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [2:0]  r_rd;
    logic [15:0] r_imm;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;

    logic        r_cmd_ready;
    logic [2:0]  r_rd_addr_a;
    logic [2:0]  r_rd_addr_b;
    logic        r_rf_wr;
    logic [2:0]  r_rf_wr_addr;
    logic [15:0] r_rf_d_in;
    logic        r_done;
    logic [15:0] r_result;
    logic        r_flag_z;
    logic        r_flag_c;

    logic [16:0] w_alu;
    logic        w_carry;
    logic        w_zero;

    // ALU: 17-bit datapath so bit 16 carries the add carry or the sub borrow
    always_comb begin
        w_alu   = 17'd0;
        w_carry = 1'b0;
        case (r_op)
            c_op_add: begin
                w_alu   = {1'b0, r_op_a} + {1'b0, r_op_b};
                w_carry = w_alu[16];
            end
            c_op_sub: begin
                // borrow wraps the 17-bit difference, setting bit 16 iff a < b
                w_alu   = {1'b0, r_op_a} - {1'b0, r_op_b};
                w_carry = w_alu[16];
            end
            c_op_and: w_alu = {1'b0, r_op_a & r_op_b};
            c_op_or:  w_alu = {1'b0, r_op_a | r_op_b};
            c_op_xor: w_alu = {1'b0, r_op_a ^ r_op_b};
            c_op_not: w_alu = {1'b0, ~r_op_a};
            c_op_mov: w_alu = {1'b0, r_op_a};
            c_op_ldi: w_alu = {1'b0, r_imm};
            default:  w_alu = 17'd0;
        endcase
        w_zero = (w_alu[15:0] == 16'h0000);
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= 3'd0;
            r_rd         <= 3'd0;
            r_imm        <= 16'd0;
            r_op_a       <= 16'd0;
            r_op_b       <= 16'd0;
            r_cmd_ready  <= 1'b1;
            r_rd_addr_a  <= 3'd0;
            r_rd_addr_b  <= 3'd0;
            r_rf_wr      <= 1'b0;
            r_rf_wr_addr <= 3'd0;
            r_rf_d_in    <= 16'd0;
            r_done       <= 1'b0;
            r_result     <= 16'd0;
            r_flag_z     <= 1'b0;
            r_flag_c     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_op        <= bus.cmd_op;
                        r_rd        <= bus.cmd_rd;
                        r_imm       <= bus.cmd_imm;
                        // read addresses are presented through READ and then held
                        r_rd_addr_a <= bus.cmd_rs1;
                        r_rd_addr_b <= bus.cmd_rs2;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    // operands captured before any write-back, so rd may alias rs1/rs2
                    r_op_a  <= bus.rf_d_out_a;
                    r_op_b  <= bus.rf_d_out_b;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_result     <= w_alu[15:0];
                    r_flag_z     <= w_zero;
                    r_flag_c     <= w_carry;
                    r_rf_d_in    <= w_alu[15:0];
                    r_rf_wr_addr <= r_rd;
                    r_rf_wr      <= 1'b1;
                    r_done       <= 1'b1;
                    r_state      <= ST_WB;
                end
                ST_WB: begin
                    r_rf_wr     <= 1'b0;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_rf_wr     <= 1'b0;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.rf_rd_addr_a = r_rd_addr_a;
    assign bus.rf_rd_addr_b = r_rd_addr_b;
    assign bus.rf_wr        = r_rf_wr;
    assign bus.rf_wr_addr   = r_rf_wr_addr;
    assign bus.rf_d_in      = r_rf_d_in;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
    assign bus.flag_z       = r_flag_z;
    assign bus.flag_c       = r_flag_c;

endmodule
`default_nettype wire

// File: tb/tb_rf_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_seq
//  Description : Self-checking bench for rf_seq with a behavioural register
//                file, table-driven command vectors and an expected-write
//                scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_seq;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rf_seq_if bus ();

    rf_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural register file: async clear, combinational read
    logic [15:0] rf_mem [8];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0000;
        end else if (bus.rf_wr) begin
            rf_mem[bus.rf_wr_addr] <= bus.rf_d_in;
        end
    end
    assign bus.rf_d_out_a = rf_mem[bus.rf_rd_addr_a];
    assign bus.rf_d_out_b = rf_mem[bus.rf_rd_addr_b];

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic [15:0] data;
        logic        z;
        logic        c;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        z;
        logic        c;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_wr     = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rf_wr) n_wr <= n_wr + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic [15:0] imm, input logic [15:0] data,
                                input logic z, input logic c);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.data = data; v.z = z; v.c = c;
        return v;
    endfunction

    // write-back monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done || bus.rf_wr) begin
                chk("wr_done_align", {31'd0, bus.rf_wr}, {31'd0, bus.done});
            end
            if (bus.done) begin
                chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.rf_wr_addr, bus.rf_d_in);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("wr_addr", {29'd0, bus.rf_wr_addr}, {29'd0, e.addr});
                    chk("rf_d_in", {16'd0, bus.rf_d_in}, {16'd0, e.data});
                    chk("result",  {16'd0, bus.result}, {16'd0, e.data});
                    chk("flag_z",  {31'd0, bus.flag_z}, {31'd0, e.z});
                    chk("flag_c",  {31'd0, bus.flag_c}, {31'd0, e.c});
                    chk("latency", cyc - e.acc, 32'd2);
                end
            end
        end
        prev_done <= bus.done;
    end

    task automatic drive(input vec_t v);
        bus.cmd_op  = v.op;
        bus.cmd_rd  = v.rd;
        bus.cmd_rs1 = v.rs1;
        bus.cmd_rs2 = v.rs2;
        bus.cmd_imm = v.imm;
    endtask

    task automatic push_exp(input vec_t v, input int acc);
        exp_t e;
        e.addr = v.rd; e.data = v.data; e.z = v.z; e.c = v.c; e.acc = acc;
        sb_q.push_back(e);
    endtask

    // present one command, wait (bounded) for acceptance, check read addresses
    task automatic send(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        drive(v);
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got cmd_ready 0 expected 1");
        end
        push_exp(v, cyc + 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("rd_addr_a", {29'd0, bus.rf_rd_addr_a}, {29'd0, v.rs1});
        chk("rd_addr_b", {29'd0, bus.rf_rd_addr_b}, {29'd0, v.rs2});
        chk("ready_low_read", {31'd0, bus.cmd_ready}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending writes expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"},  {31'd0, bus.cmd_ready}, 32'd1);
        chk({tag, "_rf_wr"},  {31'd0, bus.rf_wr}, 32'd0);
        chk({tag, "_done"},   {31'd0, bus.done}, 32'd0);
        chk({tag, "_addr_a"}, {29'd0, bus.rf_rd_addr_a}, 32'd0);
        chk({tag, "_addr_b"}, {29'd0, bus.rf_rd_addr_b}, 32'd0);
        chk({tag, "_wr_addr"},{29'd0, bus.rf_wr_addr}, 32'd0);
        chk({tag, "_d_in"},   {16'd0, bus.rf_d_in}, 32'd0);
        chk({tag, "_result"}, {16'd0, bus.result}, 32'd0);
        chk({tag, "_z"},      {31'd0, bus.flag_z}, 32'd0);
        chk({tag, "_c"},      {31'd0, bus.flag_c}, 32'd0);
    endtask

    vec_t vecs [14];

    initial begin
        int   n;
        int   acc_a;
        int   acc_b;
        int   lows;
        int   wr_before;
        vec_t va;
        vec_t vb;

        // op, rd, rs1, rs2, imm, expected data, z, c
        vecs[0]  = mk(3'b111, 3'd3, 3'd0, 3'd0, 16'hCDEF, 16'hCDEF, 1'b0, 1'b0); // LDI r3
        vecs[1]  = mk(3'b111, 3'd5, 3'd1, 3'd2, 16'h4567, 16'h4567, 1'b0, 1'b0); // LDI r5
        vecs[2]  = mk(3'b000, 3'd1, 3'd3, 3'd5, 16'h0000, 16'h1356, 1'b0, 1'b1); // ADD 0xCDEF+0x4567=0x1_1356
        vecs[3]  = mk(3'b001, 3'd2, 3'd5, 3'd3, 16'h0000, 16'h7778, 1'b0, 1'b1); // SUB borrow
        vecs[4]  = mk(3'b100, 3'd4, 3'd3, 3'd3, 16'h0000, 16'h0000, 1'b1, 1'b0); // XOR -> zero
        vecs[5]  = mk(3'b101, 3'd6, 3'd5, 3'd0, 16'h0000, 16'hBA98, 1'b0, 1'b0); // NOT
        vecs[6]  = mk(3'b010, 3'd0, 3'd3, 3'd5, 16'h0000, 16'h4567, 1'b0, 1'b0); // AND
        vecs[7]  = mk(3'b011, 3'd7, 3'd3, 3'd5, 16'h0000, 16'hCDEF, 1'b0, 1'b0); // OR
        vecs[8]  = mk(3'b110, 3'd0, 3'd2, 3'd6, 16'hFFFF, 16'h7778, 1'b0, 1'b0); // MOV ignores imm
        vecs[9]  = mk(3'b001, 3'd1, 3'd3, 3'd5, 16'h0000, 16'h8888, 1'b0, 1'b0); // SUB no borrow
        vecs[10] = mk(3'b001, 3'd4, 3'd3, 3'd3, 16'h0000, 16'h0000, 1'b1, 1'b0); // SUB equal
        vecs[11] = mk(3'b111, 3'd3, 3'd4, 3'd4, 16'h8001, 16'h8001, 1'b0, 1'b0); // LDI r3
        vecs[12] = mk(3'b000, 3'd3, 3'd3, 3'd3, 16'h0000, 16'h0002, 1'b0, 1'b1); // ADD rd aliases rs
        vecs[13] = mk(3'b000, 3'd2, 3'd4, 3'd4, 16'h0000, 16'h0000, 1'b1, 1'b0); // ADD zero

        bus.cmd_valid = 1'b0;
        drive(vecs[0]);

        // reset state
        #1 reset = 1'b1;
        #2;
        chk_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // table-driven commands
        for (int i = 0; i < 14; i++) begin
            send(vecs[i]);
        end
        drain();

        // cmd_valid held high across two commands
        va = mk(3'b111, 3'd6, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        vb = mk(3'b110, 3'd5, 3'd6, 3'd1, 16'h0000, 16'h1234, 1'b0, 1'b0);
        n  = 0;
        @(negedge clk);
        drive(va);
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        push_exp(va, cyc + 1);
        @(posedge clk);
        acc_a = cyc;
        #1;
        drive(vb);
        lows = 0;
        n    = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20) begin
            lows++;
            @(negedge clk);
            n++;
        end
        push_exp(vb, cyc + 1);
        @(posedge clk);
        acc_b = cyc;
        #1;
        bus.cmd_valid = 1'b0;
        chk("hold_accept_gap", acc_b - acc_a, 32'd4);
        chk("ready_low_cycles", lows, 32'd3);
        drain();

        // reset pulsed during EXEC of LDI r7=0xFFFF
        va = mk(3'b111, 3'd7, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        wr_before = n_wr;
        send(va);
        @(posedge clk);
        #2;
        reset = 1'b1;
        sb_q.delete();
        #1;
        chk_zero_outputs("mid_reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_write_after_reset", n_wr - wr_before, 32'd0);
        chk("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);

        // first command after reset: MOV r0=r7 sees the cleared register file
        send(mk(3'b110, 3'd0, 3'd7, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0));
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
